// File: rtl/letc_axi_sram_responder_pkg.sv
// Shared AXI response/burst encodings for the SRAM responder.
// Also provides the worst-of merge used to accumulate per-beat write responses.
package letc_axi_sram_responder_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  // DECERR dominates SLVERR, which dominates OKAY
  function automatic axi_resp_e axi_resp_worst(input axi_resp_e a, input axi_resp_e b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/letc_axi_sram_responder_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between a manager and the SRAM responder.
interface letc_axi_sram_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/letc_axi_sram_responder_sram_bank.sv
// Synchronous 1R/1W byte-enabled RAM with a single-cycle registered read.
// Read data holds its last value while the read enable is low.
module letc_axi_sram_responder_sram_bank #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    IDX_W       = 10,
  parameter string INIT_FILE   = ""
) (
  input  logic                i_clk,
  input  logic                i_rd_en,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [DATA_W-1:0]   o_rd_data,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_strb
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
    if (i_rd_en) o_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/letc_axi_sram_responder.sv
// AXI4 subordinate backed by on-chip SRAM: one outstanding transaction, INCR bursts,
// byte strobes, per-beat DECERR/SLVERR checking and read/write arbitration by a toggling priority.
module letc_axi_sram_responder
  import letc_axi_sram_responder_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                ID_W         = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                DEPTH_WORDS  = 1024,
  parameter int                READ_LATENCY = 1,
  parameter string             INIT_FILE    = ""
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  letc_axi_sram_responder_if.slave  axi,
  output logic                      o_busy
);

  localparam int          BYTES = DATA_W / 8;
  localparam int          OFF_W = $clog2(BYTES);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'(BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  function automatic axi_resp_e beat_resp(input logic [ADDR_W-1:0] addr,
                                          input logic [1:0]        burst,
                                          input logic [2:0]        size);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    if (64'(off) >= SPAN) return RESP_DECERR;
    if (burst != BURST_INCR || size > 3'(OFF_W)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> OFF_W);
  endfunction

  state_e            r_state;
  prio_e             r_prio;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_beat;
  logic [LAT_W-1:0]  r_lat_cnt;
  axi_resp_e         r_wr_acc;
  logic              r_rvalid;
  logic              r_rlast;
  axi_resp_e         r_rresp;
  logic [ID_W-1:0]   r_rid;
  logic              r_wready;
  logic              r_bvalid;
  axi_resp_e         r_bresp;
  logic [ID_W-1:0]   r_bid;

  logic              w_both_valid;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_r_hs;
  logic              w_w_hs;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_wlast_bad;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_rd_addr;
  axi_resp_e         w_ar_resp;
  axi_resp_e         w_nxt_resp;
  axi_resp_e         w_wr_resp;
  axi_resp_e         w_wr_acc_nxt;
  logic [DATA_W-1:0] w_ram_q;

  assign w_both_valid = axi.arvalid & axi.awvalid;
  assign w_ar_hs      = (r_state == ST_IDLE) & axi.arvalid & ((r_prio == PRIO_RD) | ~axi.awvalid);
  assign w_aw_hs      = (r_state == ST_IDLE) & axi.awvalid & ((r_prio == PRIO_WR) | ~axi.arvalid);
  assign w_r_hs       = r_rvalid & axi.rready;
  assign w_w_hs       = r_wready & axi.wvalid;

  assign w_addr_nxt   = r_addr + (ADDR_W'(1) << r_size);
  assign w_ar_resp    = beat_resp(axi.araddr, axi.arburst, axi.arsize);
  assign w_nxt_resp   = beat_resp(w_addr_nxt, r_burst, r_size);
  assign w_wr_resp    = beat_resp(r_addr, r_burst, r_size);
  assign w_wlast_bad  = axi.wlast != (r_beat == r_len);
  assign w_wr_acc_nxt = axi_resp_worst(axi_resp_worst(r_wr_acc, w_wr_resp),
                                       w_wlast_bad ? RESP_SLVERR : RESP_OKAY);

  // RAM is read at AR accept and at each non-final R handshake; its output then holds
  assign w_rd_en      = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_rd_addr    = w_ar_hs ? axi.araddr : w_addr_nxt;
  assign w_wr_en      = w_w_hs & (w_wr_resp == RESP_OKAY);

  letc_axi_sram_responder_sram_bank #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .INIT_FILE   (INIT_FILE)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (word_idx(w_rd_addr)),
    .o_rd_data (w_ram_q),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (word_idx(r_addr)),
    .i_wr_data (axi.wdata),
    .i_wr_strb (axi.wstrb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_prio    <= PRIO_RD;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_lat_cnt <= '0;
      r_wr_acc  <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_both_valid) r_prio <= (r_prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
          if (w_ar_hs) begin
            r_id    <= axi.arid;
            r_addr  <= axi.araddr;
            r_len   <= axi.arlen;
            r_size  <= axi.arsize;
            r_burst <= axi.arburst;
            r_beat  <= '0;
            r_rid   <= axi.arid;
            r_rresp <= w_ar_resp;
            r_rlast <= (axi.arlen == 8'd0);
            if (READ_LATENCY == 1) begin
              r_rvalid <= 1'b1;
              r_state  <= ST_RD_DATA;
            end else begin
              r_lat_cnt <= LAT_W'(READ_LATENCY - 2);
              r_state   <= ST_RD_WAIT;
            end
          end else if (w_aw_hs) begin
            r_id     <= axi.awid;
            r_addr   <= axi.awaddr;
            r_len    <= axi.awlen;
            r_size   <= axi.awsize;
            r_burst  <= axi.awburst;
            r_beat   <= '0;
            r_wr_acc <= RESP_OKAY;
            r_wready <= 1'b1;
            r_state  <= ST_WR_DATA;
          end
        end

        ST_RD_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_rvalid <= 1'b1;
            r_state  <= ST_RD_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end

        ST_RD_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_addr  <= w_addr_nxt;
              r_beat  <= r_beat + 8'd1;
              r_rresp <= w_nxt_resp;
              r_rlast <= ((r_beat + 8'd1) == r_len);
              if (READ_LATENCY != 1) begin
                r_rvalid  <= 1'b0;
                r_lat_cnt <= LAT_W'(READ_LATENCY - 2);
                r_state   <= ST_RD_WAIT;
              end
            end
          end
        end

        ST_WR_DATA: begin
          if (w_w_hs) begin
            r_addr   <= w_addr_nxt;
            r_beat   <= r_beat + 8'd1;
            r_wr_acc <= w_wr_acc_nxt;
            // beat count, not wlast, ends the burst
            if (r_beat == r_len) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_wr_acc_nxt;
              r_bid    <= r_id;
              r_state  <= ST_WR_RESP;
            end
          end
        end

        ST_WR_RESP: begin
          if (axi.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign axi.arready = w_ar_hs;
  assign axi.awready = w_aw_hs;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.bid     = r_bid;
  assign axi.rvalid  = r_rvalid;
  assign axi.rlast   = r_rlast;
  assign axi.rresp   = r_rresp;
  assign axi.rid     = r_rid;
  // errored read beats return zero
  assign axi.rdata   = (r_rresp == RESP_OKAY) ? w_ram_q : '0;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_letc_axi_sram_responder.sv
// Directed bench for the AXI SRAM responder: single/burst transfers, strobes, errors,
// arbitration priority and asynchronous reset mid-burst.
module tb_letc_axi_sram_responder;
  import letc_axi_sram_responder_pkg::*;

  logic clk;
  logic i_rst;
  logic o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wbuf    [4];
  logic [31:0] rd_data [4];
  logic [31:0] rd_hold [4];
  logic        rd_last [4];
  logic [1:0]  rd_resp [4];
  logic [3:0]  rd_id;
  logic [1:0]  resp;
  int          lat;

  letc_axi_sram_responder_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  letc_axi_sram_responder #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .ID_W         (4),
    .BASE_ADDR    (32'h0),
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (1),
    .INIT_FILE    ("")
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .axi    (axi),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge clk);
    axi.awid = 4'h3; axi.awaddr = addr; axi.awlen = len;
    axi.awsize = 3'd2; axi.awburst = burst; axi.awvalid = 1'b1;
    #1; n = 0;
    while (!axi.awready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("aw_timeout", 1, 0);
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
    int n;
    @(negedge clk);
    axi.arid = 4'h5; axi.araddr = addr; axi.arlen = len;
    axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    #1; n = 0;
    while (!axi.arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("ar_timeout", 1, 0);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  // Entered at the first negedge after AW accept.
  task automatic w_beats(input logic [7:0] len, input logic [3:0] strb, output logic [1:0] bresp_o);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      axi.wdata = wbuf[b]; axi.wstrb = strb; axi.wlast = (b == int'(len)); axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 1, 0);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
    n = 0;
    while (!axi.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_timeout", 1, 0);
    bresp_o = axi.bresp;
    chk("bid", axi.bid, 4'h3);
    @(negedge clk);
    axi.bready = 1'b0;
    chk("bvalid_drop", axi.bvalid, 0);
  endtask

  // Entered at the first negedge after AR accept; lat counts edges from accept to rvalid.
  task automatic r_beats(input logic [7:0] len, input bit toggle, output int lat_o);
    int n;
    lat_o = 1; n = 0;
    axi.rready = !toggle;
    for (int b = 0; b <= int'(len); b++) begin
      while (!axi.rvalid && n < 50) begin @(negedge clk); n++; if (b == 0) lat_o++; end
      if (n >= 50) chk("r_timeout", 1, 0);
      rd_data[b] = axi.rdata;
      rd_last[b] = axi.rlast;
      rd_resp[b] = axi.rresp;
      rd_id      = axi.rid;
      if (toggle) begin
        @(negedge clk);
        rd_hold[b] = axi.rdata;
        chk("r_hold_valid", axi.rvalid, 1);
        axi.rready = 1'b1;
      end
      @(negedge clk);
      if (toggle) axi.rready = 1'b0;
    end
    axi.rready = 1'b0;
    chk("r_done_rvalid", axi.rvalid, 0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] strb, output logic [1:0] bresp_o);
    aw_phase(addr, len, burst);
    w_beats(len, strb, bresp_o);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle, output int lat_o);
    ar_phase(addr, len);
    r_beats(len, toggle, lat_o);
  endtask

  initial begin
    i_rst = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (10) @(negedge clk);

    chk("rst_arready", axi.arready, 0);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready",  axi.wready,  0);
    chk("rst_rvalid",  axi.rvalid,  0);
    chk("rst_bvalid",  axi.bvalid,  0);
    chk("rst_rlast",   axi.rlast,   0);
    chk("rst_rresp",   axi.rresp,   RESP_OKAY);
    chk("rst_bresp",   axi.bresp,   RESP_OKAY);
    chk("rst_busy",    o_busy,      0);

    // single write then read-back
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'h10, 8'd0, 2'b01, 4'hF, resp);
    chk("single_bresp", resp, RESP_OKAY);
    axi_read(32'h10, 8'd0, 1'b0, lat);
    chk("single_rdata", rd_data[0], 32'hDEADBEEF);
    chk("single_rlast", rd_last[0], 1);
    chk("single_rresp", rd_resp[0], RESP_OKAY);
    chk("single_rid",   rd_id,      4'h5);
    chk("single_lat",   lat,        1);

    // 4-beat INCR burst, read back with rready toggling
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    axi_write(32'h100, 8'd3, 2'b01, 4'hF, resp);
    chk("burst_bresp", resp, RESP_OKAY);
    axi_read(32'h100, 8'd3, 1'b1, lat);
    for (int i = 0; i < 4; i++) begin
      chk("burst_rdata", rd_data[i], 32'(i + 1));
      chk("burst_rhold", rd_hold[i], 32'(i + 1));
      chk("burst_rlast", rd_last[i], (i == 3) ? 1 : 0);
    end

    // byte strobes
    wbuf[0] = 32'hAAAAAAAA;
    axi_write(32'h200, 8'd0, 2'b01, 4'hF, resp);
    wbuf[0] = 32'h11223344;
    axi_write(32'h200, 8'd0, 2'b01, 4'h5, resp);
    chk("strb_bresp", resp, RESP_OKAY);
    axi_read(32'h200, 8'd0, 1'b0, lat);
    chk("strb_rdata", rd_data[0], 32'hAA22AA44);

    // errors: out-of-range read, WRAP write suppressed
    axi_read(32'h1000, 8'd0, 1'b0, lat);
    chk("decerr_rresp", rd_resp[0], RESP_DECERR);
    chk("decerr_rdata", rd_data[0], 32'h0);
    wbuf[0] = 32'h12345678;
    axi_write(32'h10, 8'd0, 2'b10, 4'hF, resp);
    chk("wrap_bresp", resp, RESP_SLVERR);
    axi_read(32'h10, 8'd0, 1'b0, lat);
    chk("wrap_unchanged", rd_data[0], 32'hDEADBEEF);

    // simultaneous AR/AW: read wins first
    @(negedge clk);
    axi.arid = 4'h5; axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    axi.awid = 4'h3; axi.awaddr = 32'h300; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
    #1;
    chk("pri1_arready", axi.arready, 1);
    chk("pri1_awready", axi.awready, 0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    r_beats(8'd0, 1'b0, lat);
    chk("pri1_rdata", rd_data[0], 32'h1);
    #1;
    chk("pri1_aw_after", axi.awready, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    wbuf[0] = 32'hCAFEF00D;
    w_beats(8'd0, 4'hF, resp);
    chk("pri1_bresp", resp, RESP_OKAY);

    // simultaneous again: write wins, read sees its data
    @(negedge clk);
    axi.araddr = 32'h304; axi.arvalid = 1'b1;
    axi.awaddr = 32'h304; axi.awvalid = 1'b1;
    #1;
    chk("pri2_awready", axi.awready, 1);
    chk("pri2_arready", axi.arready, 0);
    @(negedge clk);
    axi.awvalid = 1'b0;
    wbuf[0] = 32'h0BADF00D;
    w_beats(8'd0, 4'hF, resp);
    chk("pri2_bresp", resp, RESP_OKAY);
    #1;
    chk("pri2_ar_after", axi.arready, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    r_beats(8'd0, 1'b0, lat);
    chk("pri2_rdata", rd_data[0], 32'h0BADF00D);

    // async reset during beat 2 of a read burst
    ar_phase(32'h100, 8'd3);
    axi.rready = 1'b1;
    chk("rstmid_beat1", axi.rdata, 32'h1);
    @(negedge clk);
    chk("rstmid_beat2", axi.rdata, 32'h2);
    axi.rready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rstmid_rvalid", axi.rvalid, 0);
    chk("rstmid_busy",   o_busy,     0);
    @(negedge clk);
    i_rst = 1'b0;
    axi_read(32'h10, 8'd0, 1'b0, lat);
    chk("rstmid_next_rdata", rd_data[0], 32'hDEADBEEF);
    chk("rstmid_next_rlast", rd_last[0], 1);
    chk("rstmid_next_lat",   lat,        1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
